data_mem_responder: RTL and testbench

Responder end of the pipeline's data-memory interface. Accepts MEM-stage requests (address, write data, mem_read, mem_write) and services them from an internal word array after a fixed, parameterised latency. Returns read data and a stall to the hazard unit so the pipeline holds while an access is in flight. Sits between the EX/MEM register outputs and the MEM/WB register input, replacing the zero-latency data memory.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_word_array.sv | 22 ++
 rtl/data_mem_responder.sv | 111 +++++++++++
 tb/tb_data_mem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Error causes, reported as a single err pulse in DONE
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RW_BOTH  = 2'd2;

  // Misalignment dominates: it suppresses the access entirely.
  function automatic logic [1:0] err_cause(input logic [1:0] adr_lsb,
                                           input logic       rd,
                                           input logic       wr);
    if (adr_lsb != 2'b00)  return ERR_MISALIGN;
    else if (rd && wr)     return ERR_RW_BOTH;
    else                   return ERR_NONE;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word array: synchronous write, asynchronous read, no reset.
module mem_word_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Store port; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency responder for the pipeline data-memory interface.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for mem_read/mem_write; request cycle already stalls
//   ST_BUSY | counting down LATENCY cycles on the latched request
//   ST_DONE | access complete; stall low, read_data/err valid this cycle
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] adr,
  input  logic [WORD_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [WORD_W-1:0] read_data,
  output logic              stall,
  output logic              err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W+1:0]   r_adr;      // word index plus byte offset; upper bits wrap
  logic [WORD_W-1:0]   r_wdata;
  logic                r_rd;
  logic                r_wr;
  logic [WORD_W-1:0]   r_read_data;
  logic                r_err;

  logic                w_req;
  logic                w_last;
  logic [1:0]          w_cause;
  logic                w_we;
  logic [ADDR_W-1:0]   w_index;
  logic [WORD_W-1:0]   w_rdata;

  assign w_req   = mem_read | mem_write;
  assign w_last  = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_cause = err_cause(r_adr[1:0], r_rd, r_wr);
  assign w_index = r_adr[2 +: ADDR_W];
  // Read+write together is a store; misaligned stores are dropped
  assign w_we    = w_last && r_wr && (w_cause != ERR_MISALIGN);

  assign stall     = ((r_state == ST_IDLE) && w_req) || (r_state == ST_BUSY);
  assign read_data = r_read_data;
  assign err       = r_err;

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_index),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  // Request FSM: latch in IDLE, count in BUSY, present results in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_adr       <= '0;
      r_wdata     <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_read_data <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_adr   <= adr[ADDR_W+1:0];
            r_wdata <= write_data;
            r_rd    <= mem_read;
            r_wr    <= mem_write;
            r_cnt   <= CNT_LOAD;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
            r_err   <= (w_cause != ERR_NONE);
            if (r_rd && !r_wr)
              r_read_data <= (w_cause == ERR_MISALIGN) ? '0 : w_rdata;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 instance driven from a vector
// table through a scoreboard, LATENCY=1 instance for back-to-back timing.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] adr, wd;
  logic        rd, wr;
  logic [31:0] rdata;
  logic        stall, err;

  logic [31:0] adr1, wd1;
  logic        rd1, wr1;
  logic [31:0] rdata1;
  logic        stall1, err1;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .adr(adr), .write_data(wd),
    .mem_read(rd), .mem_write(wr),
    .read_data(rdata), .stall(stall), .err(err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .adr(adr1), .write_data(wd1),
    .mem_read(rd1), .mem_write(wr1),
    .read_data(rdata1), .stall(stall1), .err(err1)
  );

  typedef struct {
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_len;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        r;
    logic        w;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[14];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic checkint(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor on the LATENCY=2 instance: err must stay low while stalled,
  // and each stall run ending is a completed access checked against the queue.
  initial begin : monitor
    int   run_len;
    logic prev_stall;
    exp_t e;
    run_len    = 0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        run_len    = 0;
        prev_stall = 1'b0;
      end else begin
        if (stall) begin
          run_len++;
          check1("err_while_stall", err, 1'b0);
        end else if (prev_stall) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got completion want none");
          end else begin
            e = sb_q.pop_front();
            check32("done_rdata", rdata, e.exp_rdata);
            check1("done_err", err, e.exp_err);
            checkint("stall_len", run_len, e.exp_len);
          end
          run_len = 0;
        end
        prev_stall = stall;
      end
    end
  end

  // Called at posedge+1 with the responder idle; returns at posedge+1 in
  // the IDLE cycle following DONE. The request is withdrawn once latched.
  task automatic issue(input vec_t v);
    exp_t e;
    bit   seen;
    e.exp_rdata = v.er;
    e.exp_err   = v.ee;
    e.exp_len   = 3;
    sb_q.push_back(e);
    adr = v.a; wd = v.d; rd = v.r; wr = v.w;
    @(posedge clk); #1;
    adr = 32'h0; wd = 32'h0; rd = 1'b0; wr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no DONE want DONE within 20 cycles");
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  logic pat [6];

  initial begin : main
    vecs[0]  = '{32'h10,  32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        1'b0};
    vecs[1]  = '{32'h10,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{32'h400, 32'h11111111, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{32'h0,   32'h0,        1'b1, 1'b0, 32'h11111111, 1'b0};
    vecs[4]  = '{32'h4,   32'h22222222, 1'b0, 1'b1, 32'h11111111, 1'b0};
    vecs[5]  = '{32'h404, 32'h0,        1'b1, 1'b0, 32'h22222222, 1'b0};
    vecs[6]  = '{32'h10,  32'h00000005, 1'b0, 1'b1, 32'h22222222, 1'b0};
    vecs[7]  = '{32'h13,  32'h0,        1'b1, 1'b0, 32'h0,        1'b1};
    vecs[8]  = '{32'h2,   32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        1'b1};
    vecs[9]  = '{32'h0,   32'h0,        1'b1, 1'b0, 32'h11111111, 1'b0};
    vecs[10] = '{32'h20,  32'hA5A5A5A5, 1'b1, 1'b1, 32'h11111111, 1'b1};
    vecs[11] = '{32'h20,  32'h0,        1'b1, 1'b0, 32'hA5A5A5A5, 1'b0};
    vecs[12] = '{32'h8,   32'hCAFE0008, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0};
    vecs[13] = '{32'h8,   32'h0,        1'b1, 1'b0, 32'hCAFE0008, 1'b0};

    rst = 1'b0;
    adr = 32'h0; wd = 32'h0; rd = 1'b0; wr = 1'b0;
    adr1 = 32'h0; wd1 = 32'h0; rd1 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check32("reset_rdata", rdata, 32'h0);
    check1("reset_err", err, 1'b0);
    check1("reset_stall", stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) issue(vecs[i]);

    // Reset during the second BUSY cycle of a store
    adr = 32'h8; wd = 32'h12345678; wr = 1'b1; rd = 1'b0;
    @(posedge clk); #1;
    adr = 32'h0; wd = 32'h0; wr = 1'b0;
    @(posedge clk); #2;
    check1("pre_abort_stall", stall, 1'b1);
    rst = 1'b0;
    #1;
    check1("abort_stall", stall, 1'b0);
    check32("abort_rdata", rdata, 32'h0);
    check1("abort_err", err, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    issue('{32'h8, 32'h0, 1'b1, 1'b0, 32'hCAFE0008, 1'b0});
    check32("queue_drained", 32'(sb_q.size()), 32'h0);

    // Back-to-back store then load on the LATENCY=1 instance
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    adr1 = 32'h0; wd1 = 32'h00000077; wr1 = 1'b1; rd1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        adr1 = 32'h0; wd1 = 32'h0; wr1 = 1'b0; rd1 = 1'b1;
      end
      @(negedge clk);
      check1($sformatf("b2b_stall[%0d]", i), stall1, pat[i]);
      if (i == 2 || i == 5) check1($sformatf("b2b_err[%0d]", i), err1, 1'b0);
      if (i == 5) check32("b2b_rdata", rdata1, 32'h00000077);
      @(posedge clk); #1;
    end
    rd1 = 1'b0;
    @(negedge clk);
    check1("b2b_idle_stall", stall1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
